// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, decode-side IF/ID outputs,
// and the stall/redirect controls coming back from the pipeline.
interface instr_fetch_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_instr;
    logic       stall;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic [7:0] if_instr;
    logic [7:0] if_pc;
    logic       if_valid;
    logic       halted;

    modport master (
        output imem_addr, if_instr, if_pc, if_valid, halted,
        input  imem_instr, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, if_instr, if_pc, if_valid, halted,
        output imem_instr, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect/halt handling.
// Optional early jump resolution is enabled by defining FETCH_JUMP_PREDECODE_EN.
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [8:0] PROG_LEN = 9'd256
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] if_instr_q, if_instr_d;
    logic [7:0] if_pc_q, if_pc_d;
    logic       if_valid_q, if_valid_d;
    logic       halted_q, halted_d;
    logic [8:0] fetch_next_s;

    // PC following the instruction currently on imem_instr (9 bits so 255+1 is visible)
    always_comb begin
        fetch_next_s = {1'b0, pc_q} + 9'd1;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (bus.imem_instr[7:6] == 2'b11) begin
            fetch_next_s = {1'b0, pc_q + 8'd1 + {{2{bus.imem_instr[5]}}, bus.imem_instr[5:0]}};
        end else begin
            fetch_next_s = {1'b0, pc_q} + 9'd1;
        end
`endif
    end

    // Next-state, next-PC and IF/ID register update; redirect outranks stall
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        if (bus.redirect_valid) begin
            state_d    = ST_RUN;
            pc_d       = bus.redirect_pc;
            if_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.stall) begin
                        state_d = ST_RUN;
                    end else if ({1'b0, pc_q} >= PROG_LEN) begin
                        // Redirected past the program end: halt without delivering
                        state_d    = ST_HALT;
                        if_valid_d = 1'b0;
                    end else begin
                        if_instr_d = bus.imem_instr;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        if (fetch_next_s >= PROG_LEN) begin
                            state_d = ST_HALT;
                            // Stop at the last word rather than wrapping to 0
                            if (fetch_next_s[8]) begin
                                pc_d = pc_q;
                            end else begin
                                pc_d = fetch_next_s[7:0];
                            end
                        end else begin
                            pc_d = fetch_next_s[7:0];
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.stall) begin
                        if_valid_d = if_valid_q;
                    end else begin
                        if_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    if_valid_d = 1'b0;
                end
            endcase
        end
        halted_d = (state_d == ST_HALT);
    end

    // State and pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_instr_q <= 8'h00;
            if_pc_q    <= 8'h00;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with PROG_LEN = 5; a cycle-level behavioural
// model is compared every cycle and literal expectations pin the scenarios.
module tb_instr_fetch;

    localparam int PLEN = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] mem [0:255];
    int         total = 0;
    int         bad = 0;
    bit         cmp_en = 1'b0;

    instr_fetch_if ifc();

    instr_fetch #(.RESET_PC(8'h00), .PROG_LEN(9'd5)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    assign ifc.imem_instr = mem[ifc.imem_addr];

    // Behavioural model: mode 0 = idle, 1 = running, 2 = halted
    int         m_mode = 0;
    int         m_pc = 0;
    logic [7:0] m_instr = 8'h00;
    int         m_ipc = 0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        int nxt;
        int off;
        if (!reset_n) begin
            m_mode = 0; m_pc = 0; m_instr = 8'h00; m_ipc = 0; m_valid = 1'b0;
        end else if (ifc.redirect_valid) begin
            m_pc = int'(ifc.redirect_pc); m_valid = 1'b0; m_mode = 1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (ifc.stall) begin
            m_mode = m_mode;
        end else if (m_mode == 2) begin
            m_valid = 1'b0;
        end else if (m_pc >= PLEN) begin
            m_mode = 2; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
            nxt = m_pc + 1;
`ifdef FETCH_JUMP_PREDECODE_EN
            if (m_instr[7:6] == 2'b11) begin
                off = m_instr[5] ? int'(m_instr[5:0]) - 64 : int'(m_instr[5:0]);
                nxt = (m_pc + 1 + off + 256) % 256;
            end
`endif
            if (nxt >= PLEN) begin
                m_mode = 2;
                if (nxt < 256) m_pc = nxt;
            end else begin
                m_pc = nxt;
            end
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_imem_addr", 9'(ifc.imem_addr), 9'(m_pc));
            check("m_if_valid", 9'(ifc.if_valid), 9'(m_valid));
            check("m_if_pc", 9'(ifc.if_pc), 9'(m_ipc));
            check("m_if_instr", 9'(ifc.if_instr), 9'(m_instr));
            check("m_halted", 9'(ifc.halted), 9'(m_mode == 2));
        end
    end

    task automatic pair(input string name, input logic [7:0] pc, input logic [7:0] ins);
        check({name, "_valid"}, 9'(ifc.if_valid), 9'd1);
        check({name, "_pc"}, 9'(ifc.if_pc), 9'(pc));
        check({name, "_instr"}, 9'(ifc.if_instr), 9'(ins));
    endtask

    task automatic redirect_to(input logic [7:0] pc);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = pc;
        @(negedge clk);
        ifc.redirect_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ifc.stall = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h69; mem[1] = 8'h55; mem[2] = 8'h6F; mem[3] = 8'h2C; mem[4] = 8'h91;

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_addr", 9'(ifc.imem_addr), 9'h000);
        check("rst_valid", 9'(ifc.if_valid), 9'd0);
        check("rst_halted", 9'(ifc.halted), 9'd0);
        check("rst_instr", 9'(ifc.if_instr), 9'h000);
        reset_n = 1'b1;

        @(negedge clk);
        check("idle_valid", 9'(ifc.if_valid), 9'd0);
        @(negedge clk); pair("p0", 8'd0, 8'h69);
        @(negedge clk); pair("p1", 8'd1, 8'h55);
        @(negedge clk); pair("p2", 8'd2, 8'h6F);

        ifc.stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            pair("stall", 8'd2, 8'h6F);
            check("stall_addr", 9'(ifc.imem_addr), 9'd3);
        end
        ifc.stall = 1'b0;
        @(negedge clk); pair("p3", 8'd3, 8'h2C);
        @(negedge clk); pair("p4", 8'd4, 8'h91);
        check("halt_set", 9'(ifc.halted), 9'd1);
        @(negedge clk);
        check("halt_valid", 9'(ifc.if_valid), 9'd0);
        check("halt_addr", 9'(ifc.imem_addr), 9'd5);
        @(negedge clk);
        check("halt_addr2", 9'(ifc.imem_addr), 9'd5);

        redirect_to(8'h00);
        check("unhalt", 9'(ifc.halted), 9'd0);
        check("unhalt_valid", 9'(ifc.if_valid), 9'd0);
        @(negedge clk); pair("rd0", 8'd0, 8'h69);
        @(negedge clk); pair("rd1", 8'd1, 8'h55);
        @(negedge clk); pair("rd2", 8'd2, 8'h6F);

        ifc.stall = 1'b1;
        redirect_to(8'h01);
        ifc.stall = 1'b0;
        check("rs_bubble", 9'(ifc.if_valid), 9'd0);
        check("rs_addr", 9'(ifc.imem_addr), 9'd1);
        @(negedge clk); pair("rs1", 8'd1, 8'h55);

        mem[1] = 8'hFF;
        redirect_to(8'h01);
        check("j_bubble", 9'(ifc.if_valid), 9'd0);
        @(negedge clk); pair("j1", 8'd1, 8'hFF);
`ifdef FETCH_JUMP_PREDECODE_EN
        @(negedge clk); pair("jloop1", 8'd1, 8'hFF);
        @(negedge clk); pair("jloop2", 8'd1, 8'hFF);
        check("jloop_halted", 9'(ifc.halted), 9'd0);
`else
        @(negedge clk); pair("jseq2", 8'd2, 8'h6F);
        @(negedge clk); pair("jseq3", 8'd3, 8'h2C);
`endif

        redirect_to(8'h07);
        check("far_valid", 9'(ifc.if_valid), 9'd0);
        check("far_halted", 9'(ifc.halted), 9'd0);
        @(negedge clk);
        check("far_valid2", 9'(ifc.if_valid), 9'd0);
        check("far_halted2", 9'(ifc.halted), 9'd1);

        redirect_to(8'h00);
        @(negedge clk); pair("pre_rst", 8'd0, 8'h69);
        reset_n = 1'b0;
        ifc.stall = 1'b1;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 8'h03;
        @(negedge clk);
        check("mrst_addr", 9'(ifc.imem_addr), 9'h000);
        check("mrst_valid", 9'(ifc.if_valid), 9'd0);
        check("mrst_pc", 9'(ifc.if_pc), 9'h000);
        check("mrst_instr", 9'(ifc.if_instr), 9'h000);
        check("mrst_halted", 9'(ifc.halted), 9'd0);
        reset_n = 1'b1;
        ifc.stall = 1'b0;
        ifc.redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        pair("post_rst", 8'd0, 8'h69);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
